// File: rtl/dest_router_pkg.sv
// -----------------------------------------------------------------------------
// dest_router_pkg
//   Shared definitions for the destination router slice:
//     - state_t           : holding-register state (EMPTY / READY / BLOCKED)
//     - DEST_LSB_DEFAULT  : default bit position of the 2-bit destination field
//     - NUM_DEST          : number of output FIFOs served by the router
//     - dest_onehot()     : 2-bit destination -> one-hot push vector
// -----------------------------------------------------------------------------
package dest_router_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        READY   = 2'd1,
        BLOCKED = 2'd2
    } state_t;

    localparam int unsigned DEST_LSB_DEFAULT = 8;
    localparam int unsigned NUM_DEST         = 4;

    function automatic logic [NUM_DEST-1:0] dest_onehot(input logic [1:0] dest);
        return NUM_DEST'(1) << dest;
    endfunction

endpackage

// File: rtl/dest_router_counter.sv
// -----------------------------------------------------------------------------
// dest_counter
//   Free-running push counter for one destination; wraps modulo 2^CNT_W.
//   Ports:
//     clk    : clock, rising edge
//     reset  : synchronous, active-high; clears the count
//     inc_i  : increment at this edge
//     cnt_o  : current count
// -----------------------------------------------------------------------------
module dest_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (inc_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/dest_router.sv
// -----------------------------------------------------------------------------
// dest_router
//   Routes words from the arbiter mux into one of four output FIFOs selected by
//   the 2-bit field in_data[DEST_LSB+1:DEST_LSB]. A single holding register H
//   buffers the word; it issues when its destination FIFO is not almost full.
//   Optional per-destination push counters: define DEST_ROUTER_CNT_EN.
//   Ports:
//     clk, reset             : clock (rising edge), synchronous active-high reset
//     in_valid, in_data      : word offered by the arbiter mux
//     in_ready               : word accepted this cycle (stalls arbiter pops)
//     almost_full_P0..P3     : almost-full flags of the output FIFOs
//     push_F0..F3            : registered push strobes (at most one high)
//     out_data               : registered data bus shared by all output FIFOs
//     cnt_P0..P3             : words pushed per destination (0 when disabled)
// -----------------------------------------------------------------------------
module dest_router
    import dest_router_pkg::*;
#(
    parameter int unsigned DATA_W   = 10,
    parameter int unsigned DEST_LSB = DEST_LSB_DEFAULT,
    parameter int unsigned CNT_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              almost_full_P0,
    input  logic              almost_full_P1,
    input  logic              almost_full_P2,
    input  logic              almost_full_P3,
    output logic              push_F0,
    output logic              push_F1,
    output logic              push_F2,
    output logic              push_F3,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  cnt_P0,
    output logic [CNT_W-1:0]  cnt_P1,
    output logic [CNT_W-1:0]  cnt_P2,
    output logic [CNT_W-1:0]  cnt_P3
);

    logic [DATA_W-1:0]   h_data_q,   h_data_d;
    logic                h_valid_q,  h_valid_d;
    logic [NUM_DEST-1:0] push_q,     push_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;

    logic [1:0]          dest;
    logic [NUM_DEST-1:0] almost_full;
    state_t              state;
    logic                accept;

    assign almost_full = {almost_full_P3, almost_full_P2, almost_full_P1, almost_full_P0};
    assign dest        = h_data_q[DEST_LSB +: 2];

    // State is a pure function of H and the live almost-full flag, so a flag
    // rising at the issuing edge blocks that push.
    always_comb begin
        state = EMPTY;
        if (h_valid_q) begin
            state = almost_full[dest] ? BLOCKED : READY;
        end
    end

    assign in_ready = (state != BLOCKED);
    assign accept   = in_valid && in_ready;

    always_comb begin
        h_data_d   = h_data_q;
        h_valid_d  = h_valid_q;
        push_d     = '0;
        out_data_d = out_data_q;

        if (state == READY) begin
            push_d     = dest_onehot(dest);
            out_data_d = h_data_q;
            h_valid_d  = 1'b0;
        end
        // A new acceptance overrides the clear above: issue and refill in the
        // same edge sustains one word per cycle.
        if (accept) begin
            h_data_d  = in_data;
            h_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_data_q   <= '0;
            h_valid_q  <= 1'b0;
            push_q     <= '0;
            out_data_q <= '0;
        end else begin
            h_data_q   <= h_data_d;
            h_valid_q  <= h_valid_d;
            push_q     <= push_d;
            out_data_q <= out_data_d;
        end
    end

    assign push_F0  = push_q[0];
    assign push_F1  = push_q[1];
    assign push_F2  = push_q[2];
    assign push_F3  = push_q[3];
    assign out_data = out_data_q;

`ifdef DEST_ROUTER_CNT_EN
    // Counters step on the same edge that registers the push strobe.
    dest_counter #(.CNT_W(CNT_W)) u_cnt0 (.clk(clk), .reset(reset), .inc_i(push_d[0]), .cnt_o(cnt_P0));
    dest_counter #(.CNT_W(CNT_W)) u_cnt1 (.clk(clk), .reset(reset), .inc_i(push_d[1]), .cnt_o(cnt_P1));
    dest_counter #(.CNT_W(CNT_W)) u_cnt2 (.clk(clk), .reset(reset), .inc_i(push_d[2]), .cnt_o(cnt_P2));
    dest_counter #(.CNT_W(CNT_W)) u_cnt3 (.clk(clk), .reset(reset), .inc_i(push_d[3]), .cnt_o(cnt_P3));
`else
    assign cnt_P0 = '0;
    assign cnt_P1 = '0;
    assign cnt_P2 = '0;
    assign cnt_P3 = '0;
`endif

endmodule

// File: tb/tb_dest_router.sv
// -----------------------------------------------------------------------------
// tb_dest_router
//   Self-checking bench for dest_router: directed scenarios with literal
//   expectations, then randomized traffic compared every cycle against a
//   queue-based model of the router.
// -----------------------------------------------------------------------------
module tb_dest_router;

    localparam int unsigned DATA_W   = 10;
    localparam int unsigned DEST_LSB = 8;
    localparam int unsigned CNT_W    = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready;
    logic [3:0]        af = 4'b0000;
    logic              push_F0, push_F1, push_F2, push_F3;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  cnt_P0, cnt_P1, cnt_P2, cnt_P3;
    logic [3:0]        pushv;

    assign pushv = {push_F3, push_F2, push_F1, push_F0};

    dest_router #(
        .DATA_W  (DATA_W),
        .DEST_LSB(DEST_LSB),
        .CNT_W   (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .almost_full_P0(af[0]),
        .almost_full_P1(af[1]),
        .almost_full_P2(af[2]),
        .almost_full_P3(af[3]),
        .push_F0       (push_F0),
        .push_F1       (push_F1),
        .push_F2       (push_F2),
        .push_F3       (push_F3),
        .out_data      (out_data),
        .cnt_P0        (cnt_P0),
        .cnt_P1        (cnt_P1),
        .cnt_P2        (cnt_P2),
        .cnt_P3        (cnt_P3)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Words waiting for their FIFO; a word leaves the head when its FIFO is
    // not almost full, and a new word is taken only while the head is not stuck.
    logic [DATA_W-1:0] pend[$];
    logic [3:0]        m_push = '0;
    logic [DATA_W-1:0] m_out  = '0;
    int unsigned       m_cnt[4];
    bit                chk_en = 1'b0;

    function automatic int unsigned dst(input logic [DATA_W-1:0] w);
        return int'(w[DEST_LSB +: 2]);
    endfunction

    function automatic bit m_stuck();
        return (pend.size() > 0) && af[dst(pend[0])];
    endfunction

    function automatic logic [31:0] exp_cnt(input int unsigned k);
`ifdef DEST_ROUTER_CNT_EN
        return 32'(m_cnt[k]);
`else
        return 32'(k - k);
`endif
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            pend.delete();
            m_push = '0;
            m_out  = '0;
            for (int k = 0; k < 4; k++) m_cnt[k] = 0;
            chk_en = 1'b1;
        end else begin
            bit stuck;
            stuck  = m_stuck();
            m_push = '0;
            if (pend.size() > 0 && !stuck) begin
                int unsigned d;
                d         = dst(pend[0]);
                m_push[d] = 1'b1;
                m_out     = pend.pop_front();
                m_cnt[d]  = (m_cnt[d] + 1) % (1 << CNT_W);
            end
            if (in_valid && !stuck) pend.push_back(in_data);
        end
    end

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("m_push",     32'(pushv),    32'(m_push));
            check("m_out_data", 32'(out_data), 32'(m_out));
            check("m_in_ready", 32'(in_ready), 32'(!m_stuck()));
            check("m_cnt_P0",   32'(cnt_P0),   exp_cnt(0));
            check("m_cnt_P1",   32'(cnt_P1),   exp_cnt(1));
            check("m_cnt_P2",   32'(cnt_P2),   exp_cnt(2));
            check("m_cnt_P3",   32'(cnt_P3),   exp_cnt(3));
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; af = 4'b0000;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] w;

        // Reset state
        do_reset();
        check("rst_push",     32'(pushv),    32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        check("rst_cnt_P2",   32'(cnt_P2),   32'h0);

        // Single word 0x2A5 to destination 2: push two edges after acceptance
        in_valid = 1'b1; in_data = 10'h2A5;
        @(negedge clk);
        in_valid = 1'b0;
        check("lat_push_e1", 32'(pushv), 32'h0);
        @(negedge clk);
        check("lat_push_e2", 32'(pushv),    32'h4);
        check("lat_out_e2",  32'(out_data), 32'h2A5);
        @(negedge clk);
        check("lat_push_e3", 32'(pushv), 32'h0);

        // Four back-to-back words, destinations 0..3
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("b2b_in_ready", 32'(in_ready), 32'h1);
            if (i >= 2) check("b2b_push", 32'(pushv), 32'(1 << (i - 2)));
            in_valid = 1'b1;
            w = DATA_W'((i << DEST_LSB) | (8'h10 + i));
            in_data = w;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b_push_2", 32'(pushv), 32'h4);
        @(negedge clk);
        check("b2b_push_3", 32'(pushv),    32'h8);
        check("b2b_out_3",  32'(out_data), 32'h313);

        // Destination 1 almost full: held for 5 cycles, then released
        @(negedge clk);
        af = 4'b0010; in_valid = 1'b1; in_data = 10'h155;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("blk_in_ready", 32'(in_ready), 32'h0);
            check("blk_push",     32'(pushv),    32'h0);
            @(negedge clk);
        end
        af = 4'b0000;
        @(negedge clk);
        check("rel_push",     32'(pushv),    32'h2);
        check("rel_out",      32'(out_data), 32'h155);
        check("rel_in_ready", 32'(in_ready), 32'h1);

        // Flag rising at the very edge a READY destination-0 word would issue
        @(negedge clk);
        in_valid = 1'b1; in_data = 10'h0AB;
        @(negedge clk);
        in_valid = 1'b0; af = 4'b0001;
        @(negedge clk);
        check("late_af_push",     32'(pushv),    32'h0);
        check("late_af_in_ready", 32'(in_ready), 32'h0);
        af = 4'b0000;
        @(negedge clk);
        check("late_af_rel_push", 32'(pushv),    32'h1);
        check("late_af_rel_out",  32'(out_data), 32'h0AB);

        // Reset while BLOCKED discards the held word
        do_reset();
        af = 4'b0010; in_valid = 1'b1; in_data = 10'h13C;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rstblk_in_ready", 32'(in_ready), 32'h0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; af = 4'b0000;
        check("rstblk_in_ready_after", 32'(in_ready), 32'h1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rstblk_no_push", 32'(pushv), 32'h0);
        end
        check("rstblk_cnt_P1", 32'(cnt_P1), 32'h0);

        // 257 words to destination 3: counter wraps to 1
        do_reset();
        for (int i = 0; i < 257; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = DATA_W'((3 << DEST_LSB) | (i & 8'hFF));
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
`ifdef DEST_ROUTER_CNT_EN
        check("wrap_cnt_P3", 32'(cnt_P3), 32'h1);
`else
        check("wrap_cnt_P3", 32'(cnt_P3), 32'h0);
`endif
        check("wrap_cnt_P0", 32'(cnt_P0), 32'h0);

        // Randomized traffic, checked every cycle by the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            reset    = ($urandom_range(0, 299) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = DATA_W'($urandom);
            for (int k = 0; k < 4; k++) af[k] = ($urandom_range(0, 9) < 3);
        end
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0; af = 4'b0000;
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dest_router.md
DEST_ROUTER -- requirements
Module: dest_router

Interface
REQ-001 SHALL have parameter DATA_W, default 10: word width, equal to the arbiter mux output width.
REQ-002 SHALL have parameter DEST_LSB, default 8: LSB of the 2-bit destination field, in_data[DEST_LSB+1:DEST_LSB].
REQ-003 SHALL have parameter CNT_W, default 8: per-destination push counter width.
REQ-004 SHALL have port clk, input, 1: clock; all logic is on the rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1: a word from the arbiter mux is present.
REQ-007 SHALL have port in_data, input, DATA_W: word from the arbiter mux.
REQ-008 SHALL have port in_ready, output, 1: the router accepts a word this cycle; fed back to the arbiter to stall its pops.
REQ-009 SHALL have ports almost_full_P0..P3, input, 1 each: almost-full flags of the output FIFOs.
REQ-010 SHALL have ports push_F0..F3, output, 1 each: registered push strobes to the output FIFOs.
REQ-011 SHALL have port out_data, output, DATA_W: registered data bus shared by all four output FIFOs.
REQ-012 SHALL have ports cnt_P0..P3, output, CNT_W each: count of words pushed per destination.

Function
REQ-013 SHALL hold one word in holding register H (data + valid); d = H.data[DEST_LSB+1:DEST_LSB].
REQ-014 SHALL implement states EMPTY (H invalid), READY (H valid, almost_full_Pd=0) and BLOCKED (H valid, almost_full_Pd=1).
REQ-015 SHALL drive in_ready combinationally: 1 in EMPTY and READY, 0 in BLOCKED.
REQ-016 SHALL accept a word at a rising edge where in_valid=1 and in_ready=1; in_data loads into H.
REQ-017 SHALL, at an edge in READY, register push_Fd=1, every other push_F=0 and out_data=H.data.
REQ-018 SHALL, at an edge in EMPTY or BLOCKED, register all push_F=0 and leave out_data at its last value.
REQ-019 SHALL, when the held word is issued and a new word is accepted at the same edge, load H with the new word and keep H valid (sustained 1 word/cycle).
REQ-020 SHALL, when the held word is issued with no new acceptance at that edge, clear H.valid.
REQ-021 SHALL have a latency of 2 edges from acceptance to push_F visible, when the destination is not almost full.
REQ-022 SHALL assert at most one push_F in any cycle.
REQ-023 SHALL decide on the almost_full_P value sampled at the issuing edge; a flag rising at that same edge blocks the push.
REQ-024 SHALL keep H unchanged in BLOCKED until almost_full_Pd falls, then issue at the next edge; no word is ever dropped or duplicated.
REQ-025 SHALL ignore in_data whenever in_valid=0.

Reset
REQ-026 SHALL, while reset=1 at an edge, clear H.valid, push_F0..F3, out_data and cnt_P0..P3 to 0; in_ready then reads 1.
REQ-027 SHALL discard a held word when reset is asserted mid-operation; no push is issued for it.

Configuration
REQ-028 SHALL, with DEST_ROUTER_CNT_EN defined, increment cnt_Pd by 1 at each edge where push_Fd is registered 1, wrapping modulo 2^CNT_W.
REQ-029 SHALL, with DEST_ROUTER_CNT_EN undefined, keep the cnt_P ports present, tie them to 0 and instantiate no counter logic.

Structure
REQ-030 SHALL place the state encoding (EMPTY/READY/BLOCKED) and the default destination-field position in the shared router package.
REQ-031 SHALL implement the per-destination counter as one sub-module, dest_counter, instantiated four times under DEST_ROUTER_CNT_EN.

Verification
REQ-032 SHALL cover: reset, then in_data=10'h2A5 (d=2) with all almost_full=0 -> push_F2=1 and out_data=10'h2A5 two edges after acceptance; other pushes stay 0.
REQ-033 SHALL cover: four back-to-back words with d=0,1,2,3 -> push_F0..F3 on four consecutive cycles, in_ready held at 1.
REQ-034 SHALL cover: almost_full_P1=1, word d=1 -> in_ready=0 and no push for 5 cycles; almost_full_P1 drops -> push_F1 at the next edge, in_ready back to 1.
REQ-035 SHALL cover: reset asserted while BLOCKED -> H cleared, no push ever issued for the held word, cnt_P1 stays 0.
REQ-036 SHALL cover, with DEST_ROUTER_CNT_EN defined and CNT_W=8: 257 words to d=3 -> cnt_P3 = 1 (wrap).
REQ-037 SHALL cover: almost_full_P0 rising at the same edge a READY d=0 word would issue -> push suppressed, state goes to BLOCKED.
